// File: rtl/sl_pkg.sv
// rtl/sl_pkg.sv - shared state encoding and helpers for street_light_ctrl_mc
package sl_pkg;

    typedef enum logic [1:0] {
        DAY   = 2'b00,
        DUSK  = 2'b01,
        NIGHT = 2'b11,
        DAWN  = 2'b10
    } sl_state_e;

    function automatic logic is_lit(input sl_state_e state);
        return (state == NIGHT) || (state == DAWN);
    endfunction

endpackage

// File: rtl/sl_tick_gen.sv
// rtl/sl_tick_gen.sv - free-running divider producing a one-clk debounce tick strobe
module sl_tick_gen #(
    parameter int TICK_DIV = 200000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Strobe decoded from the counter so it lines up with the wrap cycle
    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/street_light_ctrl_mc.sv
// rtl/street_light_ctrl_mc.sv - multi-channel debounced day/night lamp controller with PWM dimming; optional STREET_LIGHT_OVERRIDE_EN
module street_light_ctrl_mc
    import sl_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int TICK_DIV       = 200000,
    parameter int DEBOUNCE_TICKS = 8,
    parameter int PWM_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] sensor,
    input  logic [PWM_W-1:0]  brightness,
`ifdef STREET_LIGHT_OVERRIDE_EN
    input  logic [NUM_CH-1:0] force_en,
    input  logic [NUM_CH-1:0] force_val,
`endif
    output logic [NUM_CH-1:0] light_on,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              tick
);

    localparam int DCW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DCW-1:0] D_LAST = DCW'(DEBOUNCE_TICKS - 1);

    logic              w_tick;
    logic [NUM_CH-1:0] r_sync1;
    logic [NUM_CH-1:0] r_sync2;
    logic [PWM_W-1:0]  r_pwm_cnt;
    logic              w_pwm_on;
    logic [NUM_CH-1:0] w_lit_next;
    logic [NUM_CH-1:0] r_light_on;
    logic [NUM_CH-1:0] r_pwm_out;

    sl_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_sync1   <= sensor;
            r_sync2   <= r_sync1;
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
        end
    end

    // All-ones brightness must hold the lamp fully on, which the compare alone cannot reach
    assign w_pwm_on = (brightness == {PWM_W{1'b1}}) || (r_pwm_cnt < brightness);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sl_state_e      r_state;
        sl_state_e      w_state_nxt;
        logic [DCW-1:0] r_cnt;
        logic [DCW-1:0] w_cnt_nxt;
        logic           w_s;

        assign w_s = r_sync2[g];

        // A sensor reversal is tested before the tick so it wins a same-cycle collision
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                DAY: begin
                    if (w_s) begin
                        w_state_nxt = DUSK;
                        w_cnt_nxt   = '0;
                    end
                end
                DUSK: begin
                    if (!w_s) begin
                        w_state_nxt = DAY;
                        w_cnt_nxt   = '0;
                    end else if (w_tick) begin
                        if (r_cnt == D_LAST) begin
                            w_state_nxt = NIGHT;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + DCW'(1);
                        end
                    end
                end
                NIGHT: begin
                    if (!w_s) begin
                        w_state_nxt = DAWN;
                        w_cnt_nxt   = '0;
                    end
                end
                DAWN: begin
                    if (w_s) begin
                        w_state_nxt = NIGHT;
                        w_cnt_nxt   = '0;
                    end else if (w_tick) begin
                        if (r_cnt == D_LAST) begin
                            w_state_nxt = DAY;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + DCW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = DAY;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= DAY;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

`ifdef STREET_LIGHT_OVERRIDE_EN
        assign w_lit_next[g] = force_en[g] ? force_val[g] : is_lit(r_state);
`else
        assign w_lit_next[g] = is_lit(r_state);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_light_on <= '0;
            r_pwm_out  <= '0;
        end else begin
            r_light_on <= w_lit_next;
            r_pwm_out  <= w_lit_next & {NUM_CH{w_pwm_on}};
        end
    end

    assign light_on = r_light_on;
    assign pwm_out  = r_pwm_out;
    assign tick     = w_tick;

endmodule

// File: tb/tb_street_light_ctrl_mc.sv
// tb/tb_street_light_ctrl_mc.sv - directed self-checking bench for street_light_ctrl_mc
module tb_street_light_ctrl_mc;

    localparam int NUM_CH         = 2;
    localparam int TICK_DIV       = 4;
    localparam int DEBOUNCE_TICKS = 3;
    localparam int PWM_W          = 4;

    logic              clk;
    logic              reset;
    logic [NUM_CH-1:0] sensor;
    logic [PWM_W-1:0]  brightness;
`ifdef STREET_LIGHT_OVERRIDE_EN
    logic [NUM_CH-1:0] force_en;
    logic [NUM_CH-1:0] force_val;
`endif
    logic [NUM_CH-1:0] light_on;
    logic [NUM_CH-1:0] pwm_out;
    logic              tick;

    int n_checks;
    int n_fail;
    int cyc;

    street_light_ctrl_mc #(
        .NUM_CH        (NUM_CH),
        .TICK_DIV      (TICK_DIV),
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
        .PWM_W         (PWM_W)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .sensor    (sensor),
        .brightness(brightness),
`ifdef STREET_LIGHT_OVERRIDE_EN
        .force_en  (force_en),
        .force_val (force_val),
`endif
        .light_on  (light_on),
        .pwm_out   (pwm_out),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // cyc counts active posedges since the last reset release; samples are taken at negedges
    task automatic step();
        @(negedge clk);
        if (!reset) cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic pwm_window(input string tag, input logic [PWM_W-1:0] b);
        int ones;
        int mism;
        logic exp_bit;
        ones = 0;
        mism = 0;
        brightness = b;
        step_to(cyc + 4);
        for (int k = 0; k < 16; k++) begin
            step();
            exp_bit = (b == 4'hF) || (((cyc - 1) % 16) < int'(b));
            if (pwm_out[0]) ones++;
            if (pwm_out !== {2{exp_bit}}) mism++;
        end
        check({tag, "_ones"}, ones, (b == 4'hF) ? 16 : int'(b));
        check({tag, "_pattern_mism"}, mism, 0);
    endtask

    initial begin
        int acc;
        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        reset      = 1'b1;
        sensor     = '0;
        brightness = '0;
`ifdef STREET_LIGHT_OVERRIDE_EN
        force_en   = '0;
        force_val  = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_light_on", light_on, 0);
        check("rst_pwm_out", pwm_out, 0);
        check("rst_tick", tick, 0);

        reset = 1'b0;
        cyc   = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("tick_c%0d", cyc), tick, (cyc % 4) == 3);
        end
        acc = 0;
        while (cyc < 100) begin
            step();
            if (light_on != 0 || pwm_out != 0) acc++;
        end
        check("day_hold_outputs", acc, 0);

        // ch0 dark at cyc 100: DUSK at 103, ticks 103/107/111, NIGHT at 112, lamp at 113
        sensor[0] = 1'b1;
        step_to(112);
        check("ch0_before_commit", light_on, 2'b00);
        step();
        check("ch0_lit", light_on, 2'b01);

        step_to(120);
        sensor[1] = 1'b1;
        step_to(126);
        sensor[1] = 1'b0;
        acc = 0;
        while (cyc < 160) begin
            step();
            if (light_on[1]) acc++;
        end
        check("ch1_glitch_rejected", acc, 0);
        check("ch0_still_lit", light_on[0], 1);

        // ch1 dark at cyc 160: DUSK at 163, ticks 163/167/171, lamp at 173
        sensor[1] = 1'b1;
        step_to(172);
        check("ch1_before_commit", light_on, 2'b01);
        step();
        check("both_lit", light_on, 2'b11);

        step_to(180);
        pwm_window("pwm_b4", 4'd4);
        pwm_window("pwm_b15", 4'd15);
        pwm_window("pwm_b0", 4'd0);

        brightness = 4'd15;
        step();
        step();
        check("lit_pwm_full", pwm_out, 2'b11);
        #2 reset = 1'b1;
        #1;
        check("async_rst_light_on", light_on, 0);
        check("async_rst_pwm_out", pwm_out, 0);

        sensor = 2'b01;
        step();
        reset = 1'b0;
        cyc   = 0;
        // DUSK at 3, ticks at 3 and 7 leave cnt=2 by cyc 9
        step_to(9);
        check("dusk_no_light", light_on, 0);
        #2 reset = 1'b1;
        #1;
        check("dusk_rst_light_on", light_on, 0);
        check("dusk_rst_tick", tick, 0);
        step();
        reset = 1'b0;
        cyc   = 0;
        step_to(12);
        check("redebounce_before", light_on, 2'b00);
        step();
        check("redebounce_lit", light_on, 2'b01);

`ifdef STREET_LIGHT_OVERRIDE_EN
        step();
        force_en  = 2'b10;
        force_val = 2'b10;
        step();
        check("force_light_on1", light_on, 2'b11);
        check("force_pwm1", pwm_out[1], 1);
        force_en = 2'b00;
        step();
        check("force_release", light_on, 2'b01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
